// File: rtl/md_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, md_op, A, B, input busy, hi, lo);
   modport slave  (input start, md_op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; results are computed at
// accept and held in pend_* until the latency counter expires.
module md_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic clk,
   input logic reset_n,
   md_if.slave bus
);
   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   op_e                      op;
   logic [CNT_W-1:0]         cnt;
   logic [WIDTH-1:0]         hi, lo, pend_hi, pend_lo;
   logic signed [WIDTH-1:0]  sa, sb;
   logic signed [2*WIDTH-1:0] a_ext, b_ext;
   logic [2*WIDTH-1:0]       prod_s, prod_u;
   logic [WIDTH-1:0]         q_s, r_s, q_u, r_u;

   assign op      = op_e'(bus.md_op);
   assign sa      = bus.A;
   assign sb      = bus.B;
   assign a_ext   = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
   assign b_ext   = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
   assign prod_s  = a_ext * b_ext;
   assign prod_u  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
   assign bus.busy = (cnt != '0);
   assign bus.hi   = hi;
   assign bus.lo   = lo;

   // Divide-by-zero and signed overflow get fixed results instead of the divider output.
   always_comb begin
      q_s = '1;
      r_s = bus.A;
      q_u = '1;
      r_u = bus.A;
      if (bus.B != '0) begin
         q_u = bus.A / bus.B;
         r_u = bus.A % bus.B;
         if (bus.A == MOST_NEG && bus.B == '1) begin
            q_s = bus.A;
            r_s = '0;
         end else begin
            q_s = sa / sb;
            r_s = sa % sb;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (bus.start) begin
         case (op)
            OP_MULT: begin
               pend_hi <= prod_s[2*WIDTH-1:WIDTH];
               pend_lo <= prod_s[WIDTH-1:0];
               cnt     <= CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
               pend_hi <= prod_u[2*WIDTH-1:WIDTH];
               pend_lo <= prod_u[WIDTH-1:0];
               cnt     <= CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
               pend_hi <= r_s;
               pend_lo <= q_s;
               cnt     <= CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
               pend_hi <= r_u;
               pend_lo <= q_u;
               cnt     <= CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi <= bus.A;
            OP_MTLO: lo <= bus.A;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// Randomized and directed checks of md_unit (32-bit default and a 16-bit variant)
// against an arithmetic reference model.
module tb_md_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned fails  = 0;
   logic [63:0] ref_hi [2];
   logic [63:0] ref_lo [2];

   md_if #(.WIDTH(32)) bus32 ();
   md_if #(.WIDTH(16)) bus16 ();

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
      .clk(clk), .reset_n(reset_n), .bus(bus32));
   md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
      .clk(clk), .reset_n(reset_n), .bus(bus16));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic st, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
      if (sel) begin
         bus16.start = st; bus16.md_op = op; bus16.A = a[15:0]; bus16.B = b[15:0];
      end else begin
         bus32.start = st; bus32.md_op = op; bus32.A = a[31:0]; bus32.B = b[31:0];
      end
   endtask

   function automatic logic [63:0] rd_hi(input bit sel);
      return sel ? {48'd0, bus16.hi} : {32'd0, bus32.hi};
   endfunction
   function automatic logic [63:0] rd_lo(input bit sel);
      return sel ? {48'd0, bus16.lo} : {32'd0, bus32.lo};
   endfunction
   function automatic logic [63:0] rd_busy(input bit sel);
      return sel ? {63'd0, bus16.busy} : {63'd0, bus32.busy};
   endfunction

   // Reference: what an accepted op leaves in hi/lo and how long busy stays up.
   function automatic void model(input int unsigned w, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input int unsigned mc, input int unsigned dc,
                                 inout logic [63:0] h, inout logic [63:0] l,
                                 output int unsigned n);
      logic [63:0] mask, up;
      longint sa, sb, q, r, most_neg;
      mask = (64'd1 << w) - 64'd1;
      sa = longint'($signed(a << (64 - w))) >>> (64 - w);
      sb = longint'($signed(b << (64 - w))) >>> (64 - w);
      most_neg = -(longint'(1) << (w - 1));
      n = 0;
      case (op)
         3'd1: begin up = 64'(sa * sb); h = (up >> w) & mask; l = up & mask; n = mc; end
         3'd2: begin up = a * b; h = (up >> w) & mask; l = up & mask; n = mc; end
         3'd3: begin
            n = dc;
            if (b == 64'd0) begin l = mask; h = a; end
            else if (sa == most_neg && sb == -1) begin l = a; h = 64'd0; end
            else begin
               q = sa / sb; r = sa - q * sb;
               l = 64'(q) & mask; h = 64'(r) & mask;
            end
         end
         3'd4: begin
            n = dc;
            if (b == 64'd0) begin l = mask; h = a; end
            else begin l = a / b; h = a % b; end
         end
         3'd5: h = a;
         3'd6: l = a;
         default: ;
      endcase
   endfunction

   task automatic issue(input bit sel, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input string tag, input bit poke);
      logic [63:0] oh, ol, nh, nl;
      int unsigned n;
      oh = ref_hi[sel]; ol = ref_lo[sel]; nh = oh; nl = ol;
      model(sel ? 32'd16 : 32'd32, op, a, b, sel ? 32'd1 : 32'd5, sel ? 32'd3 : 32'd10, nh, nl, n);
      drive(sel, 1'b1, op, a, b);
      @(posedge clk); #1;
      drive(sel, 1'b0, 3'($urandom_range(0, 7)), {32'd0, $urandom}, {32'd0, $urandom});
      for (int unsigned i = 0; i < n; i++) begin
         check({tag, ".busy"}, rd_busy(sel), 64'd1);
         check({tag, ".hi_hold"}, rd_hi(sel), oh);
         check({tag, ".lo_hold"}, rd_lo(sel), ol);
         if (poke && i == 1) drive(sel, 1'b1, 3'd6, 64'hAA, 64'd0);
         else if (poke && i == 3) drive(sel, 1'b1, 3'd3, 64'h55, 64'd3);
         else drive(sel, 1'b0, 3'd0, {32'd0, $urandom}, {32'd0, $urandom});
         @(posedge clk); #1;
      end
      drive(sel, 1'b0, 3'd0, 64'd0, 64'd0);
      check({tag, ".busy_done"}, rd_busy(sel), 64'd0);
      check({tag, ".hi"}, rd_hi(sel), nh);
      check({tag, ".lo"}, rd_lo(sel), nl);
      ref_hi[sel] = nh; ref_lo[sel] = nl;
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [2:0]  rop;
      ref_hi[0] = 64'd0; ref_lo[0] = 64'd0; ref_hi[1] = 64'd0; ref_lo[1] = 64'd0;
      drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      for (int unsigned s = 0; s < 2; s++) begin
         check("reset.hi", rd_hi(s[0]), 64'd0);
         check("reset.lo", rd_lo(s[0]), 64'd0);
         check("reset.busy", rd_busy(s[0]), 64'd0);
      end

      // Abort a division with an asynchronous reset pulse mid-flight.
      drive(1'b0, 1'b1, 3'd3, 64'd100, 64'd7);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort.busy_before", rd_busy(1'b0), 64'd1);
      reset_n = 1'b0;
      #1;
      check("abort.busy_async", rd_busy(1'b0), 64'd0);
      reset_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort.busy", rd_busy(1'b0), 64'd0);
      check("abort.hi", rd_hi(1'b0), 64'd0);
      check("abort.lo", rd_lo(1'b0), 64'd0);

      issue(1'b0, 3'd1, 64'hFFFFFFFF, 64'd2, "mult", 1'b0);
      check("mult.hi_const", rd_hi(1'b0), 64'hFFFFFFFF);
      check("mult.lo_const", rd_lo(1'b0), 64'hFFFFFFFE);
      issue(1'b0, 3'd2, 64'hFFFFFFFF, 64'd2, "multu", 1'b0);
      check("multu.hi_const", rd_hi(1'b0), 64'h00000001);
      issue(1'b0, 3'd3, 64'hFFFFFFF9, 64'd2, "div", 1'b0);
      check("div.lo_const", rd_lo(1'b0), 64'hFFFFFFFD);
      check("div.hi_const", rd_hi(1'b0), 64'hFFFFFFFF);
      issue(1'b0, 3'd4, 64'hFFFFFFF9, 64'd2, "divu", 1'b0);
      check("divu.lo_const", rd_lo(1'b0), 64'h7FFFFFFC);
      issue(1'b0, 3'd3, 64'h80000000, 64'hFFFFFFFF, "div_ovf", 1'b0);
      check("div_ovf.lo_const", rd_lo(1'b0), 64'h80000000);
      issue(1'b0, 3'd4, 64'h1234, 64'd0, "divu_zero", 1'b0);
      check("divu_zero.hi_const", rd_hi(1'b0), 64'h1234);
      issue(1'b0, 3'd3, 64'h5, 64'd0, "div_zero", 1'b0);

      issue(1'b0, 3'd1, 64'd3, 64'd4, "interlock", 1'b1);
      check("interlock.hi_const", rd_hi(1'b0), 64'd0);
      check("interlock.lo_const", rd_lo(1'b0), 64'd12);
      issue(1'b0, 3'd5, 64'h55, 64'd0, "mthi", 1'b0);
      check("mthi.lo_kept", rd_lo(1'b0), 64'd12);
      issue(1'b0, 3'd6, 64'h77, 64'd0, "mtlo", 1'b0);
      issue(1'b0, 3'd0, 64'h99, 64'h1, "op_none", 1'b0);
      issue(1'b0, 3'd7, 64'h99, 64'h1, "op_rsvd", 1'b0);

      issue(1'b1, 3'd1, 64'h8000, 64'h8000, "w16.mult", 1'b0);
      check("w16.mult.hi_const", rd_hi(1'b1), 64'h4000);
      issue(1'b1, 3'd4, 64'hFFFF, 64'h10, "w16.divu", 1'b0);
      check("w16.divu.lo_const", rd_lo(1'b1), 64'h0FFF);
      check("w16.divu.hi_const", rd_hi(1'b1), 64'h000F);
      issue(1'b1, 3'd3, 64'h8000, 64'hFFFF, "w16.div_ovf", 1'b0);

      for (int unsigned k = 0; k < 24; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = {32'd0, $urandom};
         rb  = {32'd0, $urandom};
         case ($urandom_range(0, 5))
            0: rb = 64'd0;
            1: begin ra = 64'h80000000; rb = 64'hFFFFFFFF; end
            2: rb = {32'd0, 32'($urandom_range(1, 20))};
            default: ;
         endcase
         issue(1'b0, rop, ra, rb, "rand32", 1'b0);
         issue(1'b1, rop, ra & 64'hFFFF, rb & 64'hFFFF, "rand16", 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
